// File: rtl/node_mac_seq_if.sv
// Streaming activation / weight-write / result bundle for node_mac_seq.
// master drives activations, weight writes and result acceptance; slave is the node.
interface node_mac_seq_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/node_mac_seq.sv
// Time-multiplexed float32 neuron: ReLU(sum A[i]*W[i]) with one multiplier and one adder.
// Optional bias entry/state enabled by defining NODE_MAC_BIAS_EN.
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [47:0]       p;
  logic signed [9:0] e;
  logic [22:0]       m;
  logic              g;
  logic              st;
  logic [23:0]       r;
  logic              s;

  always_comb begin
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    // round to nearest, ties to even; a mantissa carry bumps the exponent
    r = {1'b0, m} + 24'(g & (st | m[0]));
    if (r[23]) e = e + 10'sd1;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)           y = {s, 31'd0};
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)    y = {s, 8'hFF, 23'd0};
    else if (e >= 10'sd255)                             y = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                               y = {s, 31'd0};
    else                                                y = {s, e[7:0], r[22:0]};
  end
endmodule

module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]       x;
  logic [31:0]       z;
  logic [26:0]       xm;
  logic [26:0]       zm;
  logic [26:0]       zsh;
  logic [26:0]       mask;
  logic [7:0]        d;
  logic              sticky;
  logic [27:0]       s;
  logic [4:0]        lz;
  logic [26:0]       n;
  logic signed [9:0] e;
  logic [23:0]       r;

  always_comb begin
    x    = (b[30:0] > a[30:0]) ? b : a;
    z    = (b[30:0] > a[30:0]) ? a : b;
    xm   = (x[30:23] != 8'd0) ? {1'b1, x[22:0], 3'b000} : '0;
    zm   = (z[30:23] != 8'd0) ? {1'b1, z[22:0], 3'b000} : '0;
    d    = x[30:23] - z[30:23];
    mask = ~({27{1'b1}} << d);
    if (d > 8'd26) begin
      zsh    = '0;
      sticky = |zm;
    end else begin
      zsh    = zm >> d;
      sticky = |(zm & mask);
    end
    zsh[0] = zsh[0] | sticky;
    s = (x[31] ^ z[31]) ? ({1'b0, xm} - {1'b0, zsh}) : ({1'b0, xm} + {1'b0, zsh});
    lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = signed'({2'b00, x[30:23]}) + 10'sd1;
    end else begin
      n = s[26:0] << lz;
      e = signed'({2'b00, x[30:23]}) - signed'({5'd0, lz});
    end
    r = {1'b0, n[25:3]} + 24'(n[2] & (n[1] | n[0] | n[3]));
    if (r[23]) e = e + 10'sd1;
    if (x[30:23] == 8'd0)       y = {x[31] & z[31], 31'd0};
    else if (s == 28'd0)        y = '0;
    else if (e >= 10'sd255)     y = {x[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0)       y = {x[31], 31'd0};
    else                        y = {x[31], e[7:0], r[22:0]};
  end
endmodule

module node_mac_seq #(
  parameter int N_INPUTS = 15,
  parameter int WIDTH    = 32,
  parameter int RELU     = 1,
  parameter int AW       = $clog2(N_INPUTS + 1)
) (
  input logic            clk,
  input logic            rst,
  node_mac_seq_if.slave  bus
);
`ifdef NODE_MAC_BIAS_EN
  localparam int unsigned NW = N_INPUTS + 1;
  typedef enum logic [1:0] {ACC, BIAS, OUT} state_t;
`else
  localparam int unsigned NW = N_INPUTS;
  typedef enum logic [1:0] {ACC, OUT} state_t;
`endif
  localparam logic [AW:0]   NW_L = (AW + 1)'(NW);
  localparam logic [AW-1:0] LAST = AW'(N_INPUTS - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] w_q [NW];
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] beat_sum;
  logic             beat;

  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] v);
    return (RELU != 0 && v[WIDTH-1]) ? '0 : v;
  endfunction

  // Weight read is combinational, so a same-cycle write is seen by the next beat only.
  float_mult  u_mul (.a(bus.in_data), .b(w_q[cnt_q]), .y(prod));
  float_adder u_add (.a(acc_q), .b(add_b), .y(add_y));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    beat       = bus.in_valid && (state_q == ACC);
    add_b      = prod;
`ifdef NODE_MAC_BIAS_EN
    if (state_q == BIAS) add_b = w_q[N_INPUTS];
`endif
    beat_sum   = (cnt_q == '0) ? prod : add_y;
    unique case (state_q)
      ACC: begin
        if (beat) begin
          acc_d = beat_sum;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef NODE_MAC_BIAS_EN
            state_d = BIAS;
`else
            state_d    = OUT;
            out_data_d = relu(beat_sum);
`endif
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
`ifdef NODE_MAC_BIAS_EN
      BIAS: begin
        out_data_d = relu(add_y);
        state_d    = OUT;
      end
`endif
      OUT: begin
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.w_we && ({1'b0, bus.w_addr} < NW_L)) w_q[bus.w_addr] <= bus.w_data;
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != ACC) || (cnt_q != '0);
endmodule
